// File: rtl/q2_pkg.sv
// rtl/q2_pkg.sv - Shared state encoding, phase constants and sizing helpers for the Q2 sequencer
package q2_pkg;

    // Machine states; the low two bits of the architectural states are (s1,s0)
    typedef enum logic [2:0] {
        ST_FETCH = 3'b000,
        ST_DEREF = 3'b001,
        ST_LOAD  = 3'b010,
        ST_EXEC  = 3'b011,
        ST_ALU   = 3'b100
    } q2_state_e;

    // Each state or ALU bit is split into a setup phase and a write phase
    localparam logic PH_SETUP = 1'b0;
    localparam logic PH_WRITE = 1'b1;

    localparam int ALU_BITS_DEFAULT = 8;

    // Width of the ALU bit counter; never less than one bit
    function automatic int cnt_width(input int bits);
        return (bits > 1) ? $clog2(bits) : 1;
    endfunction

endpackage

// File: rtl/q2_sequencer_if.sv
// rtl/q2_sequencer_if.sv - Decode feedback, front-panel controls and machine-state outputs of the sequencer
interface q2_sequencer_if;
    logic run;
    logic step;
    logic deref;
    logic o2;
    logic s2in;
    logic s0;
    logic ns0;
    logic s1;
    logic ns1;
    logic s2;
    logic s3;
    logic ws;
    logic halted;

    // Sequencer side: consumes decode/panel inputs, produces state encoding
    modport master (
        input  run, step, deref, o2, s2in,
        output s0, ns0, s1, ns1, s2, s3, ws, halted
    );

    // Decode / panel side
    modport slave (
        output run, step, deref, o2, s2in,
        input  s0, ns0, s1, ns1, s2, s3, ws, halted
    );
endinterface

// File: rtl/q2_bit_counter.sv
// rtl/q2_bit_counter.sv - ALU bit counter with clear/enable and current/next last-bit flags
module q2_bit_counter
    import q2_pkg::*;
#(
    parameter int ALU_BITS = ALU_BITS_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last,
    output logic last_next
);
    localparam int CW = cnt_width(ALU_BITS);
    localparam logic [CW-1:0] LAST_BIT = CW'(ALU_BITS - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise advance and wrap after the final bit
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST_BIT) ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // last_next lets the owner register s2/s3 in step with the state
    assign last      = (cnt_q == LAST_BIT);
    assign last_next = (cnt_d == LAST_BIT);

endmodule

// File: rtl/q2_sequencer.sv
// rtl/q2_sequencer.sv - Q2 machine-state sequencer with two-phase timing and run/step halting
module q2_sequencer
    import q2_pkg::*;
#(
    parameter int ALU_BITS = ALU_BITS_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    q2_sequencer_if.master bus
);
    q2_state_e state_q, state_d;
    logic      phase_q, phase_d;
    logic      halted_q, halted_d;
    logic      s0_q, s0_d, ns0_q, ns0_d;
    logic      s1_q, s1_d, ns1_q, ns1_d;
    logic      s2_q, s2_d, s3_q, s3_d;
    logic      ws_q, ws_d;

    logic cnt_clr;
    logic cnt_en;
    logic cnt_last;
    logic cnt_last_next;

    // Counter is held at zero outside ALU and steps at the end of each bit's write phase
    assign cnt_clr = (state_q != ST_ALU);
    assign cnt_en  = (state_q == ST_ALU) && (phase_q == PH_WRITE);

    q2_bit_counter #(
        .ALU_BITS (ALU_BITS)
    ) u_bit_counter (
        .clk       (clk),
        .rst       (rst),
        .clr       (cnt_clr),
        .en        (cnt_en),
        .last      (cnt_last),
        .last_next (cnt_last_next)
    );

    // Next state: park at FETCH setup while halted, else alternate phases and branch after write
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        halted_d = halted_q;
        if (halted_q && (state_q == ST_FETCH) && (phase_q == PH_SETUP)) begin
            // Release takes one clock; the instruction then starts with a full setup phase
            if (bus.run || bus.step) begin
                halted_d = 1'b0;
            end
        end else if (phase_q == PH_SETUP) begin
            phase_d = PH_WRITE;
        end else begin
            phase_d = PH_SETUP;
            unique case (state_q)
                ST_FETCH: state_d = bus.deref ? ST_DEREF : (!bus.o2 ? ST_LOAD : ST_EXEC);
                ST_DEREF: state_d = !bus.o2 ? ST_LOAD : ST_EXEC;
                ST_LOAD:  state_d = ST_EXEC;
                ST_EXEC:  state_d = bus.s2in ? ST_ALU : ST_FETCH;
                ST_ALU:   state_d = cnt_last ? ST_FETCH : ST_ALU;
                default:  state_d = ST_FETCH;
            endcase
            // Instruction boundary: decide whether to park based on run only
            if (state_d == ST_FETCH) begin
                halted_d = !bus.run;
            end
        end
    end

    // Output decode from the next state so outputs and state change on the same edge
    always_comb begin
        s0_d  = (state_d == ST_DEREF) || (state_d == ST_EXEC);
        s1_d  = (state_d == ST_LOAD)  || (state_d == ST_EXEC);
        ns0_d = !s0_d;
        ns1_d = !s1_d;
        s2_d  = (state_d == ST_ALU) && !cnt_last_next;
        s3_d  = (state_d == ST_ALU) &&  cnt_last_next;
        ws_d  = phase_d;
    end

    // State, halt flag and registered outputs; reset samples run into halted
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            phase_q  <= PH_SETUP;
            halted_q <= !bus.run;
            s0_q     <= 1'b0;
            ns0_q    <= 1'b1;
            s1_q     <= 1'b0;
            ns1_q    <= 1'b1;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            ws_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            halted_q <= halted_d;
            s0_q     <= s0_d;
            ns0_q    <= ns0_d;
            s1_q     <= s1_d;
            ns1_q    <= ns1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            ws_q     <= ws_d;
        end
    end

    assign bus.s0     = s0_q;
    assign bus.ns0    = ns0_q;
    assign bus.s1     = s1_q;
    assign bus.ns1    = ns1_q;
    assign bus.s2     = s2_q;
    assign bus.s3     = s3_q;
    assign bus.ws     = ws_q;
    assign bus.halted = halted_q;

endmodule

// File: tb/tb_q2_sequencer.sv
// tb/tb_q2_sequencer.sv - Self-checking bench for q2_sequencer with ALU_BITS of 8 and 4
module tb_q2_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   instr_no;
    logic [7:0] exp_q[$];

    q2_sequencer_if if8 ();
    q2_sequencer_if if4 ();

    q2_sequencer #(.ALU_BITS(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    q2_sequencer #(.ALU_BITS(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [7:0] HALTED_VEC = 8'b1001_1000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {halted, s1, s0, ns1, ns0, s2, s3, ws}
    function automatic logic [7:0] obs(input bit sel);
        if (sel)
            return {if4.halted, if4.s1, if4.s0, if4.ns1, if4.ns0, if4.s2, if4.s3, if4.ws};
        return {if8.halted, if8.s1, if8.s0, if8.ns1, if8.ns0, if8.s2, if8.s3, if8.ws};
    endfunction

    function automatic void push_st(input bit s1, input bit s0, input bit s2, input bit s3);
        exp_q.push_back({1'b0, s1, s0, ~s1, ~s0, s2, s3, 1'b0});
        exp_q.push_back({1'b0, s1, s0, ~s1, ~s0, s2, s3, 1'b1});
    endfunction

    // Reference: the clock-by-clock output trace of one instruction
    function automatic void build(input bit d, input bit o, input bit a, input int nb);
        exp_q.delete();
        push_st(0, 0, 0, 0);
        if (d)  push_st(0, 1, 0, 0);
        if (!o) push_st(1, 0, 0, 0);
        push_st(1, 1, 0, 0);
        if (a) for (int k = 0; k < nb; k++) push_st(0, 0, k < nb - 1, k == nb - 1);
    endfunction

    task automatic set_in(input bit sel, input bit d, input bit o, input bit a);
        if (sel) begin if4.deref = d; if4.o2 = o; if4.s2in = a; end
        else     begin if8.deref = d; if8.o2 = o; if8.s2in = a; end
    endtask

    task automatic set_run(input bit sel, input bit v);
        if (sel) if4.run = v; else if8.run = v;
    endtask

    task automatic set_step(input bit sel, input bit v);
        if (sel) if4.step = v; else if8.step = v;
    endtask

    // Entered just after a negedge showing FETCH phase 0; returns at the next one
    task automatic run_instr(input bit sel, input bit d, input bit o, input bit a,
                             input int drop_at, input int step_at, input int rst_at,
                             output int n2, output int n3);
        logic [7:0] v;
        bit r;
        build(d, o, a, sel ? 4 : 8);
        set_in(sel, d, o, a);
        n2 = 0;
        n3 = 0;
        instr_no++;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) @(negedge clk);
            v = obs(sel);
            chk($sformatf("instr%0d_cyc%0d", instr_no, i), {24'd0, v}, {24'd0, exp_q[i]});
            n2 = n2 + int'(v[2]);
            n3 = n3 + int'(v[1]);
            set_step(sel, i == step_at);
            if (i == drop_at) set_run(sel, 1'b0);
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                r = sel ? if4.run : if8.run;
                chk("rst_mid_alu", {24'd0, obs(sel)}, {24'd0, !r, 7'b001_1000});
                rst = 1'b0;
                return;
            end
        end
        @(negedge clk);
        set_step(sel, 1'b0);
    endtask

    int n2, n3;

    initial begin
        checks = 0; errors = 0; instr_no = 0;
        rst = 1'b1;
        if8.run = 1'b1; if8.step = 1'b0; set_in(0, 0, 1, 0);
        if4.run = 1'b0; if4.step = 1'b0; set_in(1, 0, 1, 0);
        @(negedge clk);
        chk("reset_run8", {24'd0, obs(0)}, 32'h18);
        chk("reset_halt4", {24'd0, obs(1)}, {24'd0, HALTED_VEC});
        rst = 1'b0;

        // Plain fetch/exec loop
        for (int i = 0; i < 3; i++) run_instr(0, 0, 1, 0, -1, -1, -1, n2, n3);

        // Full path with ALU
        run_instr(0, 1, 0, 1, -1, -1, -1, n2, n3);
        chk("s2_clocks_8", n2, 14);
        chk("s3_clocks_8", n3, 2);

        // Random instructions, free running, stray step pulses ignored
        for (int i = 0; i < 12; i++)
            run_instr(0, 1'($urandom), 1'($urandom), 1'($urandom), -1,
                      int'($urandom_range(0, 7)), -1, n2, n3);

        // Drop run during ALU bit 3 with a step pulse later in the ALU
        run_instr(0, 1, 0, 1, 14, 18, -1, n2, n3);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("halt_hold%0d", i), {24'd0, obs(0)}, {24'd0, HALTED_VEC});
            @(negedge clk);
        end

        // Single step: one instruction, mid-ALU step ignored, then parked again
        if8.step = 1'b1;
        @(negedge clk);
        if8.step = 1'b0;
        run_instr(0, 0, 1, 1, -1, 10, -1, n2, n3);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rehalt%0d", i), {24'd0, obs(0)}, {24'd0, HALTED_VEC});
            @(negedge clk);
        end

        // Resume via run, with step asserted too
        if8.run = 1'b1;
        if8.step = 1'b1;
        @(negedge clk);
        if8.step = 1'b0;
        run_instr(0, 0, 0, 0, -1, -1, -1, n2, n3);

        // Reset during ALU bit 5 phase 1, then a complete ALU op
        run_instr(0, 0, 1, 1, -1, -1, 15, n2, n3);
        run_instr(0, 0, 1, 1, -1, -1, -1, n2, n3);
        chk("s2_after_rst", n2, 14);
        chk("s3_after_rst", n3, 2);

        // ALU_BITS=4 instance, released from its reset-time halt
        if8.run = 1'b0;
        set_in(1, 0, 1, 1);
        if4.run = 1'b1;
        @(negedge clk);
        run_instr(1, 0, 1, 1, -1, -1, -1, n2, n3);
        chk("s2_clocks_4", n2, 6);
        chk("s3_clocks_4", n3, 2);
        for (int i = 0; i < 6; i++)
            run_instr(1, 1'($urandom), 1'($urandom), 1'($urandom), -1, -1, -1, n2, n3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
